// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: opcode constant, default
// geometry, table entry layout and the 2-bit saturating counter step.
package branch_target_buffer_pkg;

    localparam logic [6:0] B_TYPE      = 7'b1100011;
    localparam int         BTB_ENTRIES = 16;
    localparam int         BTB_XLEN    = 32;

    // Tag is held right-aligned in a full address-width field (upper bits zero).
    typedef struct packed {
        logic                valid;
        logic [BTB_XLEN-1:0] tag;
        logic [BTB_XLEN-1:0] target;
        logic [1:0]          ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational IF-stage lookup, EX-stage
// training, misprediction detection and resolved/mispredicted branch counters.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int XLEN    = BTB_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [XLEN-1:0] IF_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic [6:0]      EX_op,
    input  logic [XLEN-1:0] EX_pc,
    input  logic [XLEN-1:0] EX_target,
    input  logic            actual_taken,
    input  logic            EX_pred_taken,
    input  logic [XLEN-1:0] EX_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int IW = $clog2(ENTRIES);

    btb_entry_t table_q [ENTRIES];

    logic [IW-1:0]   if_idx;
    logic [XLEN-1:0] if_tag;
    btb_entry_t      if_entry;
    logic            if_hit;

    logic [IW-1:0]   ex_idx;
    logic [XLEN-1:0] ex_tag;
    btb_entry_t      ex_entry;
    logic            ex_hit;
    logic            ex_is_branch;
    logic            do_update;

    // IF lookup reads the registered table, so a same-cycle update is not visible.
    always_comb begin
        if_idx      = IF_pc[IW+1:2];
        if_tag      = IF_pc >> (IW + 2);
        if_entry    = table_q[if_idx];
        if_hit      = if_entry.valid && (if_entry.tag == if_tag);
        pred_taken  = if_hit && if_entry.ctr[1];
        pred_target = pred_taken ? if_entry.target : IF_pc + XLEN'(4);
    end

    always_comb begin
        ex_idx       = EX_pc[IW+1:2];
        ex_tag       = EX_pc >> (IW + 2);
        ex_entry     = table_q[ex_idx];
        ex_hit       = ex_entry.valid && (ex_entry.tag == ex_tag);
        ex_is_branch = (EX_op == B_TYPE);
        do_update    = ex_is_branch && !stall;
        mispredict   = ex_is_branch &&
                       ((EX_pred_taken != actual_taken) ||
                        (actual_taken && (EX_pred_target != EX_target)));
        redirect_pc  = actual_taken ? EX_target : EX_pc + XLEN'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                table_q[i] <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (do_update) begin
            if (branch_cnt != '1)
                branch_cnt <= branch_cnt + 32'd1;
            if (mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + 32'd1;

            if (ex_hit) begin
                table_q[ex_idx].ctr <= sat_ctr_next(ex_entry.ctr, actual_taken);
                if (actual_taken)
                    table_q[ex_idx].target <= EX_target;
            end else if (actual_taken) begin
                table_q[ex_idx].valid  <= 1'b1;
                table_q[ex_idx].tag    <= ex_tag;
                table_q[ex_idx].target <= EX_target;
                table_q[ex_idx].ctr    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table, mid-cycle
// reset sequence, and randomized traffic against a behavioural reference model.
module tb_branch_target_buffer;

    localparam logic [6:0] B_OP   = 7'b1100011;
    localparam logic [6:0] NOP_OP = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] IF_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [6:0]  EX_op;
    logic [31:0] EX_pc;
    logic [31:0] EX_target;
    logic        actual_taken;
    logic        EX_pred_taken;
    logic [31:0] EX_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(16), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .IF_pc(IF_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .EX_op(EX_op), .EX_pc(EX_pc), .EX_target(EX_target),
        .actual_taken(actual_taken), .EX_pred_taken(EX_pred_taken),
        .EX_pred_target(EX_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    typedef struct {
        logic        stall;
        logic [31:0] if_pc;
        logic [6:0]  op;
        logic [31:0] ex_pc;
        logic [31:0] ex_target;
        logic        taken;
        logic        ex_pt;
        logic [31:0] ex_ptg;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_mis;
        logic [31:0] e_redir;
        logic [31:0] e_bcnt;
        logic [31:0] e_mcnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a 16-entry table addressed by word index mod 16.
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_bcnt, m_mcnt;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / 64;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_bcnt = '0; m_mcnt = '0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int i;
        i  = m_idx(pc);
        t  = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : pc + 32'd4;
    endtask

    function automatic logic m_mis();
        return (EX_op == B_OP) &&
               ((EX_pred_taken != actual_taken) || (actual_taken && EX_pred_target != EX_target));
    endfunction

    task automatic m_update();
        int i;
        if (EX_op == B_OP && !stall) begin
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
            if (m_mis() && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
            i = m_idx(EX_pc);
            if (m_valid[i] && m_tag[i] == m_tagof(EX_pc)) begin
                if (actual_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = EX_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (actual_taken) begin
                m_valid[i] = 1'b1; m_tag[i] = m_tagof(EX_pc); m_tgt[i] = EX_target; m_ctr[i] = 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic s, input logic [31:0] ip, input logic [6:0] op,
                         input logic [31:0] ep, input logic [31:0] et, input logic tk,
                         input logic ept, input logic [31:0] eptg);
        stall = s; IF_pc = ip; EX_op = op; EX_pc = ep; EX_target = et;
        actual_taken = tk; EX_pred_taken = ept; EX_pred_target = eptg;
    endtask

    task automatic add(input logic s, input logic [31:0] ip, input logic [6:0] op,
                       input logic [31:0] ep, input logic [31:0] et, input logic tk,
                       input logic ept, input logic [31:0] eptg,
                       input logic xpt, input logic [31:0] xptg, input logic xmis,
                       input logic [31:0] xred, input logic [31:0] xb, input logic [31:0] xm);
        vec_t v;
        v.stall = s; v.if_pc = ip; v.op = op; v.ex_pc = ep; v.ex_target = et; v.taken = tk;
        v.ex_pt = ept; v.ex_ptg = eptg; v.e_pt = xpt; v.e_ptg = xptg; v.e_mis = xmis;
        v.e_redir = xred; v.e_bcnt = xb; v.e_mcnt = xm;
        vecs.push_back(v);
    endtask

    task automatic check_vs_model(input string tag);
        logic        t;
        logic [31:0] tg;
        m_lookup(IF_pc, t, tg);
        chk({tag, ".pred_taken"},  {31'b0, pred_taken}, {31'b0, t});
        chk({tag, ".pred_target"}, pred_target, tg);
        chk({tag, ".mispredict"},  {31'b0, mispredict}, {31'b0, m_mis()});
        chk({tag, ".redirect_pc"}, redirect_pc, actual_taken ? EX_target : EX_pc + 32'd4);
        chk({tag, ".branch_cnt"},  branch_cnt, m_bcnt);
        chk({tag, ".mispred_cnt"}, mispred_cnt, m_mcnt);
    endtask

    initial begin
        logic        t;
        logic [31:0] tg;

        rst = 1'b1;
        drive(1'b0, 32'h100, NOP_OP, '0, '0, 1'b0, 1'b0, '0);
        m_reset();
        #12;
        chk("reset.branch_cnt",  branch_cnt, 32'd0);
        chk("reset.mispred_cnt", mispred_cnt, 32'd0);
        chk("reset.pred_taken",  {31'b0, pred_taken}, 32'd0);
        rst = 1'b0;

        //  stall IF_pc        op      EX_pc         EX_tgt   tk  ept ept_tgt   | pt  ptg          mis red          bcnt mcnt
        add(0, 32'h100,      NOP_OP, 32'h0,        32'h0,   0, 0, 32'h0,       0, 32'h104,      0, 32'h4,        0, 0);
        add(0, 32'h100,      B_OP,   32'h100,      32'h80,  1, 0, 32'h104,     0, 32'h104,      1, 32'h80,       0, 0);
        add(0, 32'h100,      NOP_OP, 32'h0,        32'h0,   0, 0, 32'h0,       1, 32'h80,       0, 32'h4,        1, 1);
        add(0, 32'h100,      B_OP,   32'h100,      32'h80,  0, 1, 32'h80,      1, 32'h80,       1, 32'h104,      1, 1);
        add(0, 32'h100,      B_OP,   32'h100,      32'h80,  0, 0, 32'h104,     0, 32'h104,      0, 32'h104,      2, 2);
        add(0, 32'h100,      NOP_OP, 32'h0,        32'h0,   0, 0, 32'h0,       0, 32'h104,      0, 32'h4,        3, 2);
        add(0, 32'h140,      B_OP,   32'h140,      32'h300, 1, 0, 32'h144,     0, 32'h144,      1, 32'h300,      3, 2);
        add(0, 32'h100,      NOP_OP, 32'h0,        32'h0,   0, 0, 32'h0,       0, 32'h104,      0, 32'h4,        4, 3);
        add(0, 32'h140,      NOP_OP, 32'h0,        32'h0,   0, 0, 32'h0,       1, 32'h300,      0, 32'h4,        4, 3);
        add(1, 32'h140,      B_OP,   32'h140,      32'h300, 0, 1, 32'h300,     1, 32'h300,      1, 32'h144,      4, 3);
        add(0, 32'h140,      NOP_OP, 32'h0,        32'h0,   0, 0, 32'h0,       1, 32'h300,      0, 32'h4,        4, 3);
        add(0, 32'h200,      B_OP,   32'h200,      32'h400, 1, 0, 32'h204,     0, 32'h204,      1, 32'h400,      4, 3);
        add(0, 32'h200,      NOP_OP, 32'h0,        32'h0,   0, 0, 32'h0,       1, 32'h400,      0, 32'h4,        5, 4);
        add(0, 32'h200,      B_OP,   32'h200,      32'h480, 1, 1, 32'h400,     1, 32'h400,      1, 32'h480,      5, 4);
        add(0, 32'h200,      B_OP,   32'h200,      32'h480, 1, 1, 32'h480,     1, 32'h480,      0, 32'h480,      6, 5);
        add(0, 32'h200,      NOP_OP, 32'h0,        32'h0,   0, 0, 32'h0,       1, 32'h480,      0, 32'h4,        7, 5);
        add(0, 32'hFFFFFFFC, NOP_OP, 32'hFFFFFFFC, 32'h0,   0, 0, 32'h0,       0, 32'h0,        0, 32'h0,        7, 5);

        foreach (vecs[k]) begin
            vec_t v;
            string n;
            v = vecs[k];
            n = $sformatf("vec%0d", k);
            @(negedge clk);
            drive(v.stall, v.if_pc, v.op, v.ex_pc, v.ex_target, v.taken, v.ex_pt, v.ex_ptg);
            #1;
            chk({n, ".pred_taken"},  {31'b0, pred_taken}, {31'b0, v.e_pt});
            chk({n, ".pred_target"}, pred_target, v.e_ptg);
            chk({n, ".mispredict"},  {31'b0, mispredict}, {31'b0, v.e_mis});
            chk({n, ".redirect_pc"}, redirect_pc, v.e_redir);
            chk({n, ".branch_cnt"},  branch_cnt, v.e_bcnt);
            chk({n, ".mispred_cnt"}, mispred_cnt, v.e_mcnt);
            m_update();
        end

        // Reset raised mid-cycle with a taken branch pending: clears at once, update lost.
        @(negedge clk);
        drive(1'b0, 32'h2C4, B_OP, 32'h2C4, 32'h500, 1'b1, 1'b0, 32'h2C8);
        #2 rst = 1'b1;
        #1;
        chk("midrst.branch_cnt_async", branch_cnt, 32'd0);
        chk("midrst.pred_target_async", pred_target, 32'h2C8);
        chk("midrst.mispredict", {31'b0, mispredict}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        drive(1'b0, 32'h2C4, NOP_OP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("midrst.pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("midrst.pred_target", pred_target, 32'h2C8);
        chk("midrst.branch_cnt", branch_cnt, 32'd0);

        for (int c = 0; c < 600; c++) begin
            logic [31:0] ip, ep, et;
            logic [6:0]  op;
            logic        tk;
            @(negedge clk);
            ip = ({30'b0, 2'($urandom_range(0, 3))} << 28) | (32'($urandom_range(0, 47)) << 2);
            ep = ($urandom_range(0, 3) == 0) ? ip :
                 (({30'b0, 2'($urandom_range(0, 3))} << 28) | (32'($urandom_range(0, 47)) << 2));
            if ($urandom_range(0, 31) == 0) ep = 32'hFFFFFFFC;
            et = 32'($urandom_range(0, 7)) << 6;
            tk = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 3) != 0) ? B_OP : NOP_OP;
            if ($urandom_range(0, 1) == 1) m_lookup(ep, t, tg);
            else begin
                t  = 1'($urandom_range(0, 1));
                tg = 32'($urandom_range(0, 7)) << 6;
            end
            drive(($urandom_range(0, 7) == 0), ip, op, ep, et, tk, t, tg);
            #1;
            check_vs_model($sformatf("rnd%0d", c));
            m_update();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
